// File: rtl/z80_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : z80_io_pkg
// Brief    : Shared state encoding and defaults for the Z80 bus/pad interface.
// Revision : 1.0 - initial release
// ============================================================================
package z80_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } bus_state_e;

  localparam logic c_strobe_rst     = 1'b1;
  localparam int   c_addr_w_def     = 16;
  localparam int   c_data_w_def     = 8;
  localparam int   c_sync_stages_def = 2;
  localparam int   c_turn_cyc_def   = 1;

endpackage : z80_io_pkg
`default_nettype wire

// File: rtl/z80_bus_io_sync.sv
`default_nettype none
// ============================================================================
// Module   : io_sync
// Brief    : STAGES-deep single-bit synchroniser, async active-low reset to 1.
// Revision : 1.0 - initial release
// ============================================================================
module io_sync
  import z80_io_pkg::*;
#(
  parameter int STAGES = c_sync_stages_def
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule : io_sync
`default_nettype wire

// File: rtl/z80_bus_io.sv
`default_nettype none
// ============================================================================
// Module   : z80_bus_io
// Brief    : Z80 core <-> pad ring interface: registered pads, input
//            synchronisers, write/turnaround data-bus FSM and NMI latch.
// Config   : BUS_IO_NMI_LATCH_EN - latch NMI falling edges until acknowledged
// Revision : 1.0 - initial release
// ============================================================================
module z80_bus_io
  import z80_io_pkg::*;
#(
  parameter int ADDR_W      = c_addr_w_def,
  parameter int DATA_W      = c_data_w_def,
  parameter int SYNC_STAGES = c_sync_stages_def,
  parameter int TURN_CYC    = c_turn_cyc_def
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              INT_PAD,
  input  logic              NMI_PAD,
  input  logic              WAIT_PAD,
  input  logic [DATA_W-1:0] DI_PAD,
  output logic [DATA_W-1:0] DO_PAD,
  output logic              DO_OE,
  output logic [ADDR_W-1:0] ADDR_PAD,
  output logic              WR_PAD,
  output logic              MREQ_PAD,
  output logic              IORQ_PAD,
  output logic              HALT_PAD,
  output logic              M1_PAD,
  input  logic [ADDR_W-1:0] CORE_ADDR,
  input  logic [DATA_W-1:0] CORE_DO,
  input  logic              CORE_WR,
  input  logic              CORE_MREQ,
  input  logic              CORE_IORQ,
  input  logic              CORE_HALT,
  input  logic              CORE_M1,
  output logic [DATA_W-1:0] CORE_DI,
  output logic              CORE_INT,
  output logic              CORE_WAIT,
  output logic              CORE_NMI_REQ,
  input  logic              CORE_NMI_ACK
);

  localparam int               CNT_W       = $clog2(TURN_CYC + 1);
  localparam logic [CNT_W-1:0] c_turn_load = CNT_W'(TURN_CYC - 1);

  logic [ADDR_W-1:0] addr_pad_q, addr_pad_d;
  logic [DATA_W-1:0] do_pad_q, do_pad_d;
  logic [DATA_W-1:0] core_di_q, core_di_d;
  logic [4:0]        strobe_q, strobe_d;
  bus_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_oe_q, do_oe_d;
  logic              bus_cyc, wr_req, rd_req;
  logic              int_sync, nmi_sync, wait_sync;

  io_sync #(.STAGES(SYNC_STAGES)) u_sync_int  (.clk(CLK), .rst_n(RESET), .i_d(INT_PAD),  .o_q(int_sync));
  io_sync #(.STAGES(SYNC_STAGES)) u_sync_nmi  (.clk(CLK), .rst_n(RESET), .i_d(NMI_PAD),  .o_q(nmi_sync));
  io_sync #(.STAGES(SYNC_STAGES)) u_sync_wait (.clk(CLK), .rst_n(RESET), .i_d(WAIT_PAD), .o_q(wait_sync));

  assign bus_cyc = !CORE_MREQ || !CORE_IORQ;
  assign wr_req  = !CORE_WR && bus_cyc;
  assign rd_req  =  CORE_WR && bus_cyc;

  always_comb begin
    addr_pad_d = CORE_ADDR;
    do_pad_d   = CORE_DO;
    strobe_d   = {CORE_WR, CORE_MREQ, CORE_IORQ, CORE_HALT, CORE_M1};
    state_d    = state_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE:  if (wr_req) state_d = DRIVE;
      DRIVE: if (!wr_req) begin
        state_d = TURN;
        cnt_d   = c_turn_load;
      end
      TURN: begin
        if (wr_req)               state_d = DRIVE;
        else if (cnt_q == '0)     state_d = IDLE;
        else                      cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // OE is derived from the next state so it toggles on the same edge as WR_PAD
    do_oe_d   = (state_d == DRIVE);
    core_di_d = (state_q == IDLE && rd_req) ? DI_PAD : core_di_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_pad_q <= '0;
      do_pad_q   <= '0;
      core_di_q  <= '0;
      strobe_q   <= {5{c_strobe_rst}};
      state_q    <= IDLE;
      cnt_q      <= '0;
      do_oe_q    <= 1'b0;
    end else begin
      addr_pad_q <= addr_pad_d;
      do_pad_q   <= do_pad_d;
      core_di_q  <= core_di_d;
      strobe_q   <= strobe_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      do_oe_q    <= do_oe_d;
    end
  end

  assign ADDR_PAD = addr_pad_q;
  assign DO_PAD   = do_pad_q;
  assign DO_OE    = do_oe_q;
  assign CORE_DI  = core_di_q;
  assign {WR_PAD, MREQ_PAD, IORQ_PAD, HALT_PAD, M1_PAD} = strobe_q;
  assign CORE_INT  = int_sync;
  // Hold the core in wait states while a read overlaps the bus turnaround
  assign CORE_WAIT = wait_sync & ~(state_q == TURN && rd_req);

`ifdef BUS_IO_NMI_LATCH_EN
  logic nmi_prev_q, nmi_prev_d;
  logic nmi_pend_q, nmi_pend_d;

  always_comb begin
    nmi_prev_d = nmi_sync;
    nmi_pend_d = nmi_pend_q;
    if (CORE_NMI_ACK)              nmi_pend_d = 1'b0;
    if (nmi_prev_q && !nmi_sync)   nmi_pend_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      nmi_prev_q <= 1'b1;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_prev_q <= nmi_prev_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  assign CORE_NMI_REQ = nmi_pend_q;
`else
  logic unused_nmi_ack;
  assign unused_nmi_ack = CORE_NMI_ACK;
  assign CORE_NMI_REQ   = ~nmi_sync;
`endif

endmodule : z80_bus_io
`default_nettype wire

// File: tb/tb_z80_bus_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_z80_bus_io
// Brief    : Self-checking bench for z80_bus_io (directed scenarios plus a
//            randomized run against a cycle-level behavioural model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_z80_bus_io;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TURN_CYC    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              int_pad = 1'b1, nmi_pad = 1'b1, wait_pad = 1'b1;
  logic [DATA_W-1:0] di_pad = '0;
  logic [DATA_W-1:0] do_pad;
  logic              do_oe;
  logic [ADDR_W-1:0] addr_pad;
  logic              wr_pad, mreq_pad, iorq_pad, halt_pad, m1_pad;
  logic [ADDR_W-1:0] core_addr = '0;
  logic [DATA_W-1:0] core_do = '0;
  logic              core_wr = 1'b1, core_mreq = 1'b1, core_iorq = 1'b1;
  logic              core_halt = 1'b1, core_m1 = 1'b1;
  logic [DATA_W-1:0] core_di;
  logic              core_int, core_wait, core_nmi_req;
  logic              core_nmi_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  z80_bus_io #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .TURN_CYC(TURN_CYC)
  ) dut (
    .CLK(clk), .RESET(rst_n),
    .INT_PAD(int_pad), .NMI_PAD(nmi_pad), .WAIT_PAD(wait_pad),
    .DI_PAD(di_pad), .DO_PAD(do_pad), .DO_OE(do_oe), .ADDR_PAD(addr_pad),
    .WR_PAD(wr_pad), .MREQ_PAD(mreq_pad), .IORQ_PAD(iorq_pad),
    .HALT_PAD(halt_pad), .M1_PAD(m1_pad),
    .CORE_ADDR(core_addr), .CORE_DO(core_do), .CORE_WR(core_wr),
    .CORE_MREQ(core_mreq), .CORE_IORQ(core_iorq), .CORE_HALT(core_halt),
    .CORE_M1(core_m1), .CORE_DI(core_di), .CORE_INT(core_int),
    .CORE_WAIT(core_wait), .CORE_NMI_REQ(core_nmi_req), .CORE_NMI_ACK(core_nmi_ack)
  );

  // ---------------- behavioural reference model ----------------
  // m_quiet counts edges since the last sampled write (saturating): 0 means the
  // bus is driven, 1..TURN_CYC is the release window, above that it is free.
  int                m_quiet;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_do, m_di;
  logic [4:0]        m_strobes;
  bit                m_pend, m_nmi_last;
  bit                q_int[$], q_nmi[$], q_wait[$];

  function automatic bit f_wr();
    return !core_wr && (!core_mreq || !core_iorq);
  endfunction

  function automatic bit f_rd();
    return core_wr && (!core_mreq || !core_iorq);
  endfunction

  task automatic model_reset();
    m_quiet = TURN_CYC + 1;
    m_addr = '0; m_do = '0; m_di = '0; m_strobes = '1;
    m_pend = 1'b0; m_nmi_last = 1'b1;
    q_int.delete(); q_nmi.delete(); q_wait.delete();
    for (int i = 0; i < SYNC_STAGES; i++) begin
      q_int.push_back(1'b1); q_nmi.push_back(1'b1); q_wait.push_back(1'b1);
    end
  endtask

  task automatic model_edge();
    bit wr, rd, sync_now;
    wr = f_wr();
    rd = f_rd();
    if (m_quiet > TURN_CYC && rd) m_di = di_pad;
    if (wr) m_quiet = 0;
    else if (m_quiet <= TURN_CYC) m_quiet = m_quiet + 1;
    m_addr = core_addr;
    m_do = core_do;
    m_strobes = {core_wr, core_mreq, core_iorq, core_halt, core_m1};
    sync_now = q_nmi[0];
    if (m_nmi_last && !sync_now) m_pend = 1'b1;
    else if (core_nmi_ack) m_pend = 1'b0;
    m_nmi_last = sync_now;
    q_int.push_back(int_pad);   void'(q_int.pop_front());
    q_nmi.push_back(nmi_pad);   void'(q_nmi.pop_front());
    q_wait.push_back(wait_pad); void'(q_wait.pop_front());
  endtask

  function automatic bit m_wait_exp();
    return q_wait[0] && !(m_quiet >= 1 && m_quiet <= TURN_CYC && f_rd());
  endfunction

  function automatic bit m_nmi_exp();
`ifdef BUS_IO_NMI_LATCH_EN
    return m_pend;
`else
    return !q_nmi[0];
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    core_wr = 1'b1; core_mreq = 1'b1; core_iorq = 1'b1;
    core_halt = 1'b1; core_m1 = 1'b1; core_nmi_ack = 1'b0;
    int_pad = 1'b1; nmi_pad = 1'b1; wait_pad = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    core_addr = 16'hABCD; core_do = 8'h77; core_wr = 1'b0; core_mreq = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (addr_pad !== 16'hABCD || wr_pad !== 1'b0 || do_oe !== 1'b1) begin
      n_err++;
      $display("FAIL reset_prewrite: addr=%h wr=%b oe=%b, expected abcd 0 1", addr_pad, wr_pad, do_oe);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (addr_pad !== '0 || do_pad !== '0 || wr_pad !== 1'b1 || do_oe !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: addr=%h do=%h wr=%b oe=%b, expected 0000 00 1 0", addr_pad, do_pad, wr_pad, do_oe);
    end
    n_cmp++;
    if ({mreq_pad, iorq_pad, halt_pad, m1_pad} !== 4'hF || core_di !== '0) begin
      n_err++;
      $display("FAIL reset_strobes: strobes=%b di=%h, expected 1111 00", {mreq_pad, iorq_pad, halt_pad, m1_pad}, core_di);
    end
    n_cmp++;
    if (core_int !== 1'b1 || core_wait !== 1'b1 || core_nmi_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_core: int=%b wait=%b nmi=%b, expected 1 1 0", core_int, core_wait, core_nmi_req);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (do_oe !== 1'b0 || wr_pad !== 1'b1) begin
      n_err++;
      $display("FAIL reset_hold: oe=%b wr=%b, expected 0 1", do_oe, wr_pad);
    end
    set_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    int stall;
    int end_cyc;
    int di_cyc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      core_wr = 1'b0; core_mreq = 1'b0; core_do = 8'h5A; core_addr = ADDR_W'(16'h1000 + i);
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (do_pad !== 8'h5A || do_oe !== 1'b1) begin
        n_err++;
        $display("FAIL write_drive[%0d]: do=%h oe=%b, expected 5a 1", i, do_pad, do_oe);
      end
    end
    core_wr = 1'b1; core_mreq = 1'b0; core_do = '0; di_pad = 8'h3C;
    stall = 0; end_cyc = -1; di_cyc = -1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (core_wait === 1'b0) stall++;
      else if (stall > 0 && end_cyc < 0) end_cyc = k;
      @(posedge clk); @(negedge clk);
      if (k == 0) begin
        n_cmp++;
        if (do_oe !== 1'b0 || wr_pad !== 1'b1) begin
          n_err++;
          $display("FAIL write_release: oe=%b wr=%b, expected 0 1", do_oe, wr_pad);
        end
      end
      if (core_di === 8'h3C && di_cyc < 0) di_cyc = k;
    end
    n_cmp++;
    if (stall != TURN_CYC) begin
      n_err++;
      $display("FAIL read_stall_len: got %0d wait cycles, expected %0d", stall, TURN_CYC);
    end
    n_cmp++;
    if (di_cyc != TURN_CYC + 1 || end_cyc != TURN_CYC + 1) begin
      n_err++;
      $display("FAIL read_capture: di at cycle %0d stall end %0d, expected both %0d", di_cyc, end_cyc, TURN_CYC + 1);
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    int op_tab   [8] = '{1, 1, 0, 1, 2, 2, 2, 2};
    bit exp_wait [8] = '{1, 1, 1, 1, 1, 0, 0, 1};
    bit exp_oe   [8] = '{1, 1, 0, 1, 0, 0, 0, 0};
    do_reset();
    di_pad = 8'hC3;
    for (int j = 0; j < 8; j++) begin
      core_wr = (op_tab[j] != 1); core_mreq = (op_tab[j] == 0); core_iorq = 1'b1;
      core_do = DATA_W'(8'hA0 + j);
      #1;
      n_cmp++;
      if (core_wait !== exp_wait[j]) begin
        n_err++;
        $display("FAIL b2b_wait[%0d]: got %b, expected %b", j, core_wait, exp_wait[j]);
      end
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (do_oe !== exp_oe[j]) begin
        n_err++;
        $display("FAIL b2b_oe[%0d]: got %b, expected %b", j, do_oe, exp_oe[j]);
      end
    end
    n_cmp++;
    if (core_di !== 8'hC3) begin
      n_err++;
      $display("FAIL b2b_di: got %h, expected c3", core_di);
    end
    set_idle();
  endtask

  task automatic test_sync_pulse();
    int lows;
    int pos;
    do_reset();
    int_pad = 1'b0;
    lows = 0; pos = -1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) int_pad = 1'b1;
      if (core_int === 1'b0) begin
        lows++;
        if (pos < 0) pos = k;
      end
    end
    n_cmp++;
    if (lows != 1 || pos != SYNC_STAGES - 1) begin
      n_err++;
      $display("FAIL int_pulse: low for %0d cycles at %0d, expected 1 at %0d", lows, pos, SYNC_STAGES - 1);
    end
  endtask

`ifdef BUS_IO_NMI_LATCH_EN
  task automatic test_nmi();
    int lat;
    int bad;
    do_reset();
    nmi_pad = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (core_nmi_req === 1'b1) begin lat = k; break; end
    end
    n_cmp++;
    if (lat != SYNC_STAGES + 1) begin
      n_err++;
      $display("FAIL nmi_latency: got %0d, expected %0d", lat, SYNC_STAGES + 1);
    end
    bad = 0;
    nmi_pad = 1'b1;
    repeat (SYNC_STAGES + 3) begin
      @(posedge clk); @(negedge clk);
      if (core_nmi_req !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL nmi_hold: req dropped %0d times without ack, expected 0", bad);
    end
    // second falling edge arrives while pending; ack coincides with its detection
    nmi_pad = 1'b0;
    repeat (SYNC_STAGES) begin @(posedge clk); @(negedge clk); end
    core_nmi_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    core_nmi_ack = 1'b0;
    n_cmp++;
    if (core_nmi_req !== 1'b1) begin
      n_err++;
      $display("FAIL nmi_set_wins: got %b, expected 1", core_nmi_req);
    end
    core_nmi_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    core_nmi_ack = 1'b0;
    n_cmp++;
    if (core_nmi_req !== 1'b0) begin
      n_err++;
      $display("FAIL nmi_ack_clear: got %b, expected 0", core_nmi_req);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (core_nmi_req !== 1'b0) begin
      n_err++;
      $display("FAIL nmi_stay_clear: got %b, expected 0", core_nmi_req);
    end
    set_idle();
  endtask
`else
  task automatic test_nmi_level();
    int lat;
    int bad;
    do_reset();
    nmi_pad = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (core_nmi_req === 1'b1) begin lat = k; break; end
    end
    n_cmp++;
    if (lat != SYNC_STAGES) begin
      n_err++;
      $display("FAIL nmi_level_rise: got %0d, expected %0d", lat, SYNC_STAGES);
    end
    bad = 0;
    core_nmi_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (core_nmi_req !== 1'b1) bad++;
    end
    core_nmi_ack = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL nmi_level_ack: req low %0d times under ack, expected 0", bad);
    end
    nmi_pad = 1'b1;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); @(negedge clk);
      if (core_nmi_req === 1'b0) begin lat = k; break; end
    end
    n_cmp++;
    if (lat != SYNC_STAGES) begin
      n_err++;
      $display("FAIL nmi_level_fall: got %0d, expected %0d", lat, SYNC_STAGES);
    end
  endtask
`endif

  task automatic test_random();
    int op;
    int r;
    do_reset();
    op = 0;
    for (int it = 0; it < 600; it++) begin
      if (it == 300) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (addr_pad !== '0 || do_oe !== 1'b0 || core_di !== '0) begin
          n_err++;
          $display("FAIL rand_reset: addr=%h oe=%b di=%h, expected 0 0 0", addr_pad, do_oe, core_di);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) op = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 2));
      if (op == 0) begin
        core_wr = 1'($urandom_range(0, 1)); core_mreq = 1'b1; core_iorq = 1'b1;
      end else begin
        core_wr = (op == 2);
        core_mreq = (r == 1);
        core_iorq = (r == 0);
      end
      core_addr = ADDR_W'($urandom);
      core_do   = DATA_W'($urandom);
      di_pad    = DATA_W'($urandom);
      core_halt = 1'($urandom_range(0, 1));
      core_m1   = 1'($urandom_range(0, 1));
      wait_pad  = ($urandom_range(0, 4) != 0);
      int_pad   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) nmi_pad = ~nmi_pad;
      core_nmi_ack = ($urandom_range(0, 7) == 0);
      #1;
      n_cmp++;
      if (core_wait !== m_wait_exp()) begin
        n_err++;
        $display("FAIL rand_wait[%0d]: got %b, expected %b", it, core_wait, m_wait_exp());
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      n_cmp++;
      if (addr_pad !== m_addr || do_pad !== m_do ||
          {wr_pad, mreq_pad, iorq_pad, halt_pad, m1_pad} !== m_strobes) begin
        n_err++;
        $display("FAIL rand_pads[%0d]: addr=%h do=%h str=%b, expected %h %h %b", it, addr_pad, do_pad,
                 {wr_pad, mreq_pad, iorq_pad, halt_pad, m1_pad}, m_addr, m_do, m_strobes);
      end
      n_cmp++;
      if (do_oe !== (m_quiet == 0)) begin
        n_err++;
        $display("FAIL rand_oe[%0d]: got %b, expected %b", it, do_oe, (m_quiet == 0));
      end
      n_cmp++;
      if (core_di !== m_di) begin
        n_err++;
        $display("FAIL rand_di[%0d]: got %h, expected %h", it, core_di, m_di);
      end
      n_cmp++;
      if (core_int !== q_int[0] || core_nmi_req !== m_nmi_exp()) begin
        n_err++;
        $display("FAIL rand_sync[%0d]: int=%b nmi=%b, expected %b %b", it, core_int, core_nmi_req, q_int[0], m_nmi_exp());
      end
    end
    set_idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_sync_pulse();
`ifdef BUS_IO_NMI_LATCH_EN
    test_nmi();
`else
    test_nmi_level();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule : tb_z80_bus_io
`default_nettype wire

// File: doc/z80_bus_io.md
# z80_bus_io

Parametrised bus interface between the Z80 core and the pad ring, sitting inside the top level between the core instance and the I/O pad cells. Registers every core-to-pad output and synchronises the asynchronous control inputs. Runs a data-bus drive/turnaround state machine that stalls reads following a write, and latches NMI falling edges until the core acknowledges them. Successor to the fixed-width pad wiring, with address/data width and synchroniser depth generalised.

## Interface
- ADDR_W, 16, address bus width
- DATA_W, 8, data bus width
- SYNC_STAGES, 2, synchroniser depth for INT/NMI/WAIT (legal ≥2)
- TURN_CYC, 1, bus-release cycles after a write (legal ≥1)
- CLK  in  1  single clock
- RESET  in  1  asynchronous, active-low reset
- INT_PAD, NMI_PAD, WAIT_PAD  in  1 each  pad inputs, active-low, asynchronous
- DI_PAD  in  DATA_W  pad data in
- DO_PAD  out  DATA_W  registered data out
- DO_OE  out  1  data pad output enable, active-high
- ADDR_PAD  out  ADDR_W  registered address
- WR_PAD, MREQ_PAD, IORQ_PAD, HALT_PAD, M1_PAD  out  1 each  registered strobes, active-low
- CORE_ADDR  in  ADDR_W; CORE_DO  in  DATA_W; CORE_WR, CORE_MREQ, CORE_IORQ, CORE_HALT, CORE_M1  in  1 each (active-low)
- CORE_DI  out  DATA_W  captured read data
- CORE_INT, CORE_WAIT  out  1 each  synchronised, active-low (CORE_WAIT includes turnaround stall)
- CORE_NMI_REQ  out  1  pending NMI, active-high
- CORE_NMI_ACK  in  1  one-cycle pulse clearing CORE_NMI_REQ

## Operation
- Reset values (asynchronous, on RESET low at any time, including mid-cycle): ADDR_PAD=0, DO_PAD=0, CORE_DI=0, DO_OE=0, all *_PAD strobes=1, all sync flops=1, CORE_INT=1, CORE_WAIT=1, CORE_NMI_REQ=0, FSM=IDLE.
- Outputs: every *_PAD output is a flop of the matching CORE_* input; no logic in between.
- Synchronisers: INT/NMI/WAIT each pass through SYNC_STAGES flops; CORE_INT is the last stage.
- Definitions: wr_req = !CORE_WR && (!CORE_MREQ || !CORE_IORQ); rd_req = CORE_WR && (!CORE_MREQ || !CORE_IORQ).
- FSM (next state and DO_OE registered together):
  - IDLE (OE=0): wr_req → DRIVE; otherwise stay in IDLE.
  - DRIVE (OE=1): wr_req → stay in DRIVE; otherwise → TURN, counter loaded with TURN_CYC-1.
  - TURN (OE=0): wr_req → DRIVE (back-to-back writes allowed); counter==0 → IDLE; otherwise decrement.
- Read stall: CORE_WAIT = sync_wait & ~(FSM==TURN && rd_req). The core inserts wait states until the bus is released.
- DI capture: CORE_DI <= DI_PAD when FSM==IDLE && rd_req; otherwise hold.
- NMI: a synchronised 1→0 transition sets nmi_pend. CORE_NMI_ACK clears it. If an edge and an ACK occur in the same cycle, set wins. CORE_NMI_REQ = nmi_pend. Further edges while pending are absorbed.

## Timing
- Core→pad latency: 1 cycle for all outputs. DO_OE rises on the same edge as WR_PAD falls, and falls on the same edge as WR_PAD rises.
- Pad input→CORE_INT/sync_wait: SYNC_STAGES cycles.
- NMI_PAD fall → CORE_NMI_REQ high: SYNC_STAGES+1 cycles. ACK → REQ low: 1 cycle.
- Write end → earliest DI capture: TURN_CYC+1 cycles. CORE_WAIT is low combinationally for each TURN cycle in which rd_req is true.
- CORE_DI updates 1 cycle after a qualifying read cycle.

## Configuration
- BUS_IO_NMI_LATCH_EN defined: edge latch and ack behaviour as above.
- BUS_IO_NMI_LATCH_EN undefined: CORE_NMI_REQ = ~(synchronised NMI) (level, no latch). CORE_NMI_ACK is ignored. Edge-detect flops are not built.

## Structure
- Package z80_io_pkg holds:
  - FSM state enum (IDLE, DRIVE, TURN)
  - strobe reset constant (1)
  - default parameter constants
- Sub-module io_sync: a SYNC_STAGES-deep, 1-bit synchroniser with asynchronous active-low reset to 1. Instantiated three times.

## Test plan
- Reset: drive CORE_ADDR=16'hABCD, CORE_WR=0, then pull RESET low mid-write → ADDR_PAD=0, WR_PAD=1, DO_OE=0, FSM=IDLE immediately, without waiting for a clock edge.
- Write then read, TURN_CYC=2: write CORE_DO=8'h5A for 3 cycles, then issue a read with DI_PAD=8'h3C. Required response:
  - DO_PAD=8'h5A and DO_OE=1 for 3 cycles.
  - CORE_WAIT=0 for 2 cycles.
  - CORE_DI=8'h3C one cycle after the stall ends.
- Back-to-back writes: a second write starts during TURN → DO_OE returns to 1 with no IDLE cycle and no stall.
- NMI: NMI_PAD falls → CORE_NMI_REQ=1 after 3 cycles (SYNC_STAGES=2). It stays 1 until ACK, then returns to 0. A second edge coincident with ACK → REQ stays 1.
- Synchroniser: pulse INT_PAD low for 1 cycle → CORE_INT low for exactly 1 cycle, SYNC_STAGES cycles later.
- Macro off: NMI_PAD held low → CORE_NMI_REQ=1 regardless of ACK. Release NMI_PAD → REQ=0 after SYNC_STAGES cycles.
